// File: rtl/div_rep_sub.sv
// Unsigned repeated-subtraction divider with start/done handshake.
// Define DIV_ITER_CNT_EN to add the iter_cnt subtract-cycle counter port.
module div_rep_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
`ifdef DIV_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] quo_r;
    logic             sub_ok;

    assign sub_ok = (rem_r >= div_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem_r       <= '0;
            div_r       <= '0;
            quo_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem_r       <= dividend;
                        div_r       <= divisor;
                        quo_r       <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= (divisor == '0);
                        // Zero divisor skips SUB and reports all-ones quotient
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                        end else begin
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    if (sub_ok) begin
                        rem_r <= rem_r - div_r;
                        quo_r <= quo_r + WIDTH'(1);
                    end else begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= quo_r;
                        remainder <= rem_r;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (state == IDLE && start) begin
            iter_cnt <= '0;
        end else if (state == SUB) begin
            iter_cnt <= iter_cnt + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_div_rep_sub.sv
// Self-checking bench for div_rep_sub: cycle model plus directed vectors.
`timescale 1ns/1ps
module tb_div_rep_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
`ifdef DIV_ITER_CNT_EN
    logic [W-1:0] iter_cnt;
`endif

    int checks = 0;
    int errors = 0;

    div_rep_sub #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
`ifdef DIV_ITER_CNT_EN
        ,
        .iter_cnt   (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: which edge accepts, when results appear, what they are.
    int     cyc = 0;
    bit     m_valid = 0;
    bit     m_active = 0;
    int     m_done_cyc = -10;
    int     m_E = 0;
    int     m_itmax = 0;
    longint m_q = 0, m_r = 0, m_pq = 0, m_pr = 0;
    bit     m_dz = 0;

    always @(posedge clk) begin
        bit idle_before;
        cyc++;
        if (rst) begin
            m_valid = 1;
            m_active = 0;
            m_q = 0;
            m_r = 0;
            m_dz = 0;
            m_E = cyc;
            m_itmax = 0;
            m_done_cyc = -10;
        end else begin
            idle_before = !m_active;
            if (m_active && cyc - 1 == m_done_cyc) m_active = 0;
            if (idle_before && start) begin
                m_E = cyc;
                m_active = 1;
                if (divisor == 0) begin
                    m_dz = 1;
                    m_pq = 65535;
                    m_pr = dividend;
                    m_itmax = 0;
                    m_done_cyc = cyc;
                end else begin
                    m_dz = 0;
                    m_pq = dividend / divisor;
                    m_pr = dividend % divisor;
                    m_itmax = int'(m_pq) + 1;
                    m_done_cyc = cyc + int'(m_pq) + 1;
                end
            end
            if (m_active && cyc == m_done_cyc) begin
                m_q = m_pq;
                m_r = m_pr;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("busy", busy, m_active);
            chk("done", done, m_active && cyc == m_done_cyc);
            chk("div_by_zero", div_by_zero, m_dz);
`ifdef DIV_ITER_CNT_EN
            begin
                int el;
                el = cyc - m_E;
                chk("iter_cnt", iter_cnt, (el < m_itmax) ? el : m_itmax);
            end
`endif
        end
    end

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int e);
        @(negedge clk);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int e, output int lat);
        bit seen = 0;
        for (int i = 0; i < 66000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        lat = cyc - e;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input longint eq, input longint er,
                          input bit edz, input int elat);
        int e, lat;
        accept(a, b, e);
        wait_done(e, lat);
        chk("lit_quotient", quotient, eq);
        chk("lit_remainder", remainder, er);
        chk("lit_dz", div_by_zero, edz);
        chk("lit_latency", lat, elat);
        @(negedge clk);
        chk("lit_busy_after", busy, 0);
    endtask

    initial begin
        int e, lat;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'd100, 16'd7, 14, 2, 0, 15);
`ifdef DIV_ITER_CNT_EN
        chk("lit_iter_cnt", iter_cnt, 15);
`endif
        run_op(16'd5, 16'd9, 0, 5, 0, 1);
        run_op(16'd0, 16'd3, 0, 0, 0, 1);
        run_op(16'd12, 16'd0, 65535, 12, 1, 0);
        run_op(16'd65535, 16'd1, 65535, 0, 0, 65536);

        // Re-pulse start with new operands while SUB is running
        accept(16'd40, 16'd5, e);
        repeat (3) @(negedge clk);
        start = 1'b1;
        dividend = 16'd9;
        divisor = 16'd3;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(e, lat);
        chk("lit_ignore_q", quotient, 8);
        chk("lit_ignore_r", remainder, 0);
        chk("lit_ignore_lat", lat, 9);
        repeat (2) @(negedge clk);

        // Abort a long division with reset
        accept(16'd1000, 16'd1, e);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dz", div_by_zero, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_op(16'd9, 16'd4, 2, 1, 0, 3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
